// File: rtl/fft_peak_detect_if.sv
// Bin stream and peak-result bus for fft_peak_detect.
// The slave modport is the detector side; master is the upstream/consumer side.
interface fft_peak_detect_if #(
  parameter int DATA_WIDTH = 24,
  parameter int FFT_SIZE   = 256
);
  localparam int BIN_W = $clog2(FFT_SIZE);

  logic signed [DATA_WIDTH-1:0]   data_real_i;
  logic signed [DATA_WIDTH-1:0]   data_imag_i;
  logic                           valid_i;
  logic                           ready_o;
  logic        [BIN_W-1:0]        peak_bin_o;
  logic        [2*DATA_WIDTH-1:0] peak_power_o;
  logic                           peak_valid_o;
  logic                           peak_ready_i;
  logic                           busy_o;

  modport slave (
    input  data_real_i, data_imag_i, valid_i, peak_ready_i,
    output ready_o, peak_bin_o, peak_power_o, peak_valid_o, busy_o
  );

  modport master (
    output data_real_i, data_imag_i, valid_i, peak_ready_i,
    input  ready_o, peak_bin_o, peak_power_o, peak_valid_o, busy_o
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Finds the maximum-power bin among the first SEARCH_BINS bins of each FFT frame.
// Optional macro FFT_PEAK_DC_SKIP_EN excludes bin 0 from the search.
module fft_peak_detect #(
  parameter int DATA_WIDTH  = 24,
  parameter int FFT_SIZE    = 256,
  parameter int SEARCH_BINS = 128
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fft_peak_detect_if.slave   bus,
  output logic               dbg_state_o
);
  localparam int BIN_W = $clog2(FFT_SIZE);
  localparam int PW    = 2 * DATA_WIDTH;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_SIZE - 1);
`ifdef FFT_PEAK_DC_SKIP_EN
  localparam logic [BIN_W-1:0] INIT_BIN = BIN_W'(1);
`else
  localparam logic [BIN_W-1:0] INIT_BIN = '0;
`endif

  typedef enum logic {ACCUM = 1'b0, REPORT = 1'b1} state_t;

  state_t            state_q;
  logic              ready_q;
  logic [BIN_W-1:0]  cnt_q;
  logic              p1_valid_q, p1_last_q, p1_search_q;
  logic [BIN_W-1:0]  p1_bin_q;
  logic [PW-1:0]     p1_pwr_q;
  logic [BIN_W-1:0]  max_bin_q, max_bin_d;
  logic [PW-1:0]     max_pwr_q, max_pwr_d;
  logic [BIN_W-1:0]  peak_bin_q;
  logic [PW-1:0]     peak_pwr_q;
  logic              peak_valid_q, busy_q;

  // Both channels are valid/ready: a bin moves on a rising edge where valid_i
  // and ready_o are high; a result moves where peak_valid_o and peak_ready_i are high.
  logic xfer, hs, last_done, search_d, upd;
  logic signed [PW-1:0] re_ext, im_ext;
  logic [PW-1:0] pwr_d;

  assign xfer      = bus.valid_i & ready_q;
  assign hs        = peak_valid_q & bus.peak_ready_i;
  assign last_done = p1_valid_q & p1_last_q;

  always_comb begin
    re_ext = PW'(bus.data_real_i);
    im_ext = PW'(bus.data_imag_i);
    pwr_d  = $unsigned(re_ext * re_ext) + $unsigned(im_ext * im_ext);
`ifdef FFT_PEAK_DC_SKIP_EN
    search_d = (cnt_q != '0) && (32'(cnt_q) < SEARCH_BINS);
`else
    search_d = (32'(cnt_q) < SEARCH_BINS);
`endif
    // Strictly greater keeps the earliest index on ties.
    upd       = p1_valid_q & p1_search_q & (p1_pwr_q > max_pwr_q);
    max_bin_d = upd ? p1_bin_q : max_bin_q;
    max_pwr_d = upd ? p1_pwr_q : max_pwr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ACCUM;
      ready_q      <= 1'b1;
      cnt_q        <= '0;
      p1_valid_q   <= 1'b0;
      p1_last_q    <= 1'b0;
      p1_search_q  <= 1'b0;
      p1_bin_q     <= '0;
      p1_pwr_q     <= '0;
      max_bin_q    <= INIT_BIN;
      max_pwr_q    <= '0;
      peak_bin_q   <= '0;
      peak_pwr_q   <= '0;
      peak_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      p1_valid_q <= xfer;
      if (xfer) begin
        p1_pwr_q    <= pwr_d;
        p1_bin_q    <= cnt_q;
        p1_search_q <= search_d;
        p1_last_q   <= (cnt_q == LAST_BIN);
        cnt_q       <= (cnt_q == LAST_BIN) ? '0 : cnt_q + 1'b1;
        busy_q      <= 1'b1;
      end

      // The final bin's candidate is folded in as the result is latched,
      // and the running maximum restarts for the next frame.
      if (last_done) begin
        peak_bin_q <= max_bin_d;
        peak_pwr_q <= max_pwr_d;
        max_bin_q  <= INIT_BIN;
        max_pwr_q  <= '0;
      end else begin
        max_bin_q  <= max_bin_d;
        max_pwr_q  <= max_pwr_d;
      end

      case (state_q)
        ACCUM: begin
          if (xfer && cnt_q == LAST_BIN) begin
            ready_q <= 1'b0;
          end else if (last_done) begin
            state_q      <= REPORT;
            peak_valid_q <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        REPORT: begin
          if (hs) begin
            state_q      <= ACCUM;
            peak_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.peak_bin_o   = peak_bin_q;
  assign bus.peak_power_o = peak_pwr_q;
  assign bus.peak_valid_o = peak_valid_q;
  assign bus.busy_o       = busy_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: hand-computed peaks pushed into an
// expected queue and checked on each result handshake.
module tb_fft_peak_detect;
  localparam int DW = 24;
  localparam int N  = 256;
  localparam int SB = 128;
  localparam int BW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;

  always #5 clk = ~clk;

  fft_peak_detect_if #(.DATA_WIDTH(DW), .FFT_SIZE(N)) bus_if ();

  fft_peak_detect #(.DATA_WIDTH(DW), .FFT_SIZE(N), .SEARCH_BINS(SB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int re_a[N];
  int im_a[N];
  logic [BW-1:0]   exp_bin_q[$];
  logic [2*DW-1:0] exp_pwr_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      re_a[i] = 0;
      im_a[i] = 0;
    end
  endtask

  task automatic push_exp(input int bin, input longint pwr);
    exp_bin_q.push_back(BW'(bin));
    exp_pwr_q.push_back((2*DW)'(pwr));
  endtask

  task automatic send_bin(input int re, input int im);
    int budget;
    budget = 0;
    bus_if.valid_i     = 1'b1;
    bus_if.data_real_i = re[DW-1:0];
    bus_if.data_imag_i = im[DW-1:0];
    while (bus_if.ready_o !== 1'b1 && budget < 50) begin
      step();
      budget++;
    end
    if (bus_if.ready_o !== 1'b1) check("ready_timeout", 64'(bus_if.ready_o), 64'd1);
    step();
    bus_if.valid_i = 1'b0;
  endtask

  // Sends bins 0..last_idx; a full frame also checks the two-cycle result latency.
  task automatic send_frame(input bit gaps, input int last_idx);
    for (int i = 0; i <= last_idx; i++) begin
      send_bin(re_a[i], im_a[i]);
      if (gaps && i < last_idx && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 5)) step();
    end
    if (last_idx == N - 1) begin
      check("drain_valid", 64'(bus_if.peak_valid_o), 64'd0);
      check("drain_ready", 64'(bus_if.ready_o), 64'd0);
      check("drain_busy", 64'(bus_if.busy_o), 64'd1);
      step();
      check("latency_valid", 64'(bus_if.peak_valid_o), 64'd1);
      check("latency_state", 64'(dbg_state), 64'd1);
    end
  endtask

  task automatic get_result(input string tag, input int hold);
    int budget;
    logic [BW-1:0]   eb;
    logic [2*DW-1:0] ep;
    budget = 0;
    while (bus_if.peak_valid_o !== 1'b1 && budget < 20) begin
      step();
      budget++;
    end
    check({tag, "_valid"}, 64'(bus_if.peak_valid_o), 64'd1);
    check({tag, "_sb"}, 64'(exp_bin_q.size() != 0), 64'd1);
    eb = (exp_bin_q.size() != 0) ? exp_bin_q.pop_front() : '0;
    ep = (exp_pwr_q.size() != 0) ? exp_pwr_q.pop_front() : '0;
    bus_if.peak_ready_i = 1'b0;
    for (int k = 0; k < hold; k++) begin
      check({tag, "_hold_valid"}, 64'(bus_if.peak_valid_o), 64'd1);
      check({tag, "_hold_bin"}, 64'(bus_if.peak_bin_o), 64'(eb));
      check({tag, "_hold_pwr"}, 64'(bus_if.peak_power_o), 64'(ep));
      check({tag, "_hold_ready"}, 64'(bus_if.ready_o), 64'd0);
      step();
    end
    check({tag, "_bin"}, 64'(bus_if.peak_bin_o), 64'(eb));
    check({tag, "_pwr"}, 64'(bus_if.peak_power_o), 64'(ep));
    bus_if.peak_ready_i = 1'b1;
    step();
    bus_if.peak_ready_i = 1'b0;
    check({tag, "_post_valid"}, 64'(bus_if.peak_valid_o), 64'd0);
    check({tag, "_post_ready"}, 64'(bus_if.ready_o), 64'd0);
    check({tag, "_post_busy"}, 64'(bus_if.busy_o), 64'd0);
    step();
    check({tag, "_rearm_ready"}, 64'(bus_if.ready_o), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    bus_if.valid_i      = 1'b0;
    bus_if.data_real_i  = '0;
    bus_if.data_imag_i  = '0;
    bus_if.peak_ready_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    check("rst_valid", 64'(bus_if.peak_valid_o), 64'd0);
    check("rst_bin", 64'(bus_if.peak_bin_o), 64'd0);
    check("rst_pwr", 64'(bus_if.peak_power_o), 64'd0);
    check("rst_busy", 64'(bus_if.busy_o), 64'd0);
    check("rst_ready", 64'(bus_if.ready_o), 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);

    // Single peak at bin 37: 1000^2 + 500^2.
    clear_frame();
    re_a[37] = 1000; im_a[37] = -500;
    push_exp(37, 1250000);
    send_frame(1'b0, N - 1);
    get_result("t_bin37", 0);

    // Tie between bins 10 and 20 with random valid gaps: lower index wins.
    clear_frame();
    re_a[10] = 300; im_a[10] = 400;
    re_a[20] = 300; im_a[20] = 400;
    push_exp(10, 250000);
    send_frame(1'b1, N - 1);
    get_result("t_tie", 0);

    // Full-scale bin 200 lies outside the searched half.
    clear_frame();
    re_a[200] = -8388608; im_a[200] = -8388608;
    re_a[5] = 1;
    push_exp(5, 1);
    send_frame(1'b0, N - 1);
    get_result("t_upper", 0);

    // Large DC bin versus small bin 3.
    clear_frame();
    re_a[0] = 5000; re_a[3] = 10;
`ifdef FFT_PEAK_DC_SKIP_EN
    push_exp(3, 100);
`else
    push_exp(0, 25000000);
`endif
    send_frame(1'b0, N - 1);
    get_result("t_dc", 0);

    // All-zero frame with the consumer stalling for 10 cycles.
    clear_frame();
`ifdef FFT_PEAK_DC_SKIP_EN
    push_exp(1, 0);
`else
    push_exp(0, 0);
`endif
    send_frame(1'b0, N - 1);
    get_result("t_stall", 10);

    // Reset after bin 100 discards the partial frame.
    clear_frame();
    re_a[50] = 20000;
    send_frame(1'b0, 100);
    check("part_busy", 64'(bus_if.busy_o), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 64'(bus_if.peak_valid_o), 64'd0);
    check("mid_rst_busy", 64'(bus_if.busy_o), 64'd0);
    check("mid_rst_ready", 64'(bus_if.ready_o), 64'd1);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    clear_frame();
    re_a[7] = 30; im_a[7] = 40;
    push_exp(7, 2500);
    send_frame(1'b1, N - 1);
    get_result("t_after_rst", 0);
    extra = 0;
    repeat (20) begin
      if (bus_if.peak_valid_o === 1'b1) extra++;
      step();
    end
    check("single_result", 64'(extra), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
